pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter W, default 32, SHALL set the address width in bits.
REQ-003 Parameter STEP, default 1, SHALL set the sequential increment in address units.
REQ-004 Parameter RESET_ADDR, default 0, SHALL set the pc value loaded at reset.
REQ-005 Parameter RAS_DEPTH, default 4, minimum 1, SHALL set the number of return-address-stack (RAS) entries.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 clr_n  in  1  asynchronous active-low reset.
REQ-008 stall  in  1  when high, holds all state.
REQ-009 sel  in  2  next-pc mode: 00 seq, 01 branch, 10 jump, 11 return.
REQ-010 offset  in  W  two's-complement branch offset.
REQ-011 target  in  W  absolute jump target.
REQ-012 call  in  1  qualifies a jump as a call, pushing the return address.
REQ-013 pc  out  W  registered current instruction address.
REQ-014 pc_next  out  W  combinational value pc takes at the next edge if stall=0.
REQ-015 ras_empty  out  1  high when the RAS holds no entries.
REQ-016 ras_err  out  1  sticky flag set by a return from an empty RAS.

Function
REQ-017 State SHALL update only on a rising clk edge with stall=0; stall=1 SHALL leave pc, RAS and ras_err unchanged and ignore all other inputs.
REQ-018 sel=00 SHALL load pc+STEP, modulo 2^W, so the value wraps past all-ones.
REQ-019 sel=01 SHALL load pc+offset, signed, modulo 2^W.
REQ-020 sel=10 SHALL load target; with call=1 it SHALL also push pc+STEP (mod 2^W) on the same edge.
REQ-021 call SHALL be ignored when sel is not 10.
REQ-022 sel=11 with a non-empty RAS SHALL load the top entry and pop it on the same edge.
REQ-023 sel=11 with an empty RAS SHALL load pc+STEP, leave the RAS unchanged and set ras_err.
REQ-024 A push when the RAS is full SHALL overwrite the oldest entry circularly; the count saturates at RAS_DEPTH and no error is raised.
REQ-025 pc_next SHALL reflect REQ-018..REQ-023 for the current inputs, independent of stall.
REQ-026 ras_empty SHALL be derived from the registered entry count, valid in the same cycle as pc.
REQ-027 ras_err SHALL clear only on reset.

Reset
REQ-028 clr_n low SHALL immediately, without a clock edge, force pc=RESET_ADDR, RAS count=0, ras_empty=1 and ras_err=0; RAS entry contents are don't-care.
REQ-029 Reset asserted mid-operation, including during stall, SHALL discard any pending update.
REQ-030 The first update after clr_n rises SHALL occur at the first rising clk edge with stall=0.

Configuration
REQ-031 With macro PC_SEQ_RAS_EN defined, the RAS SHALL be built as specified above.
REQ-032 With PC_SEQ_RAS_EN undefined, no RAS storage SHALL exist: sel=11 behaves as sel=00, call is ignored, ras_empty is tied to 1, ras_err is tied to 0, and RAS_DEPTH is unused.

Verification (W=32, STEP=1, RESET_ADDR=0, RAS_DEPTH=4, macro defined unless noted)
REQ-033 Release reset, hold sel=00 for 3 edges, assert stall for 2 edges, then release for 1 edge -> pc sequence 0,1,2,3,3,3,4.
REQ-034 Branch and wrap: pc=0x0A with sel=01, offset=0xFFFFFFFC -> pc=0x06; pc=0xFFFFFFFF with sel=00 -> pc=0x00000000.
REQ-035 Call and return: pc=0x20 with sel=10, target=0x100, call=1 -> pc=0x100; sel=00 -> 0x101; sel=11 -> 0x21 and ras_empty=1.
REQ-036 Overflow and underflow: 5 nested calls from pc 0x10,0x20,0x30,0x40,0x50 -> 4 returns yield 0x51,0x41,0x31,0x21; a 5th return from pc=0x21 -> pc=0x22 and ras_err=1, which stays high until reset.
REQ-037 Asynchronous reset: with pc=0x55, ras_err=1 and 2 entries, drop clr_n between edges -> pc=0, ras_empty=1, ras_err=0 before the next edge.
REQ-038 With the macro undefined: pc=7 with sel=11 -> pc=8 and ras_err=0; pc=8 with sel=10, target=0x40, call=1 -> pc=0x40 and ras_empty stays 1.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with optional circular return-address stack
// Define PC_SEQ_RAS_EN to build the RAS; without it sel=11 steps sequentially and call is ignored.
module pc_sequencer #(
    parameter int unsigned  W          = 32,
    parameter int unsigned  STEP       = 1,
    parameter logic [W-1:0] RESET_ADDR = '0,
    parameter int unsigned  RAS_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         stall,
    input  logic [1:0]   sel,
    input  logic [W-1:0] offset,
    input  logic [W-1:0] target,
    input  logic         call,
    output logic [W-1:0] pc,
    output logic [W-1:0] pc_next,
    output logic         ras_empty,
    output logic         ras_err
);
    localparam logic [1:0]   SEL_SEQ = 2'b00;
    localparam logic [1:0]   SEL_BR  = 2'b01;
    localparam logic [1:0]   SEL_JMP = 2'b10;
    localparam logic [1:0]   SEL_RET = 2'b11;
    localparam logic [W-1:0] STEP_W  = W'(STEP);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;
    logic [W-1:0] seq_addr;
    logic [W-1:0] ret_addr;
    logic         ret_hit;

    assign seq_addr = pc_q + STEP_W;

`ifdef PC_SEQ_RAS_EN
    localparam int unsigned   PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned   CW       = $clog2(RAS_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [W-1:0]  ras_mem [RAS_DEPTH];
    logic [PW-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          push, pop, empty;

    // ptr_q is the next write slot; the newest entry sits one slot below it.
    assign empty    = (cnt_q == '0);
    assign ptr_inc  = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
    assign ptr_dec  = (ptr_q == '0) ? PTR_LAST : ptr_q - PW'(1);
    assign push     = (sel == SEL_JMP) && call;
    assign pop      = (sel == SEL_RET) && !empty;
    assign ret_hit  = !empty;
    assign ret_addr = ras_mem[ptr_dec];

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (!stall) begin
            if (push) begin
                ptr_d = ptr_inc;
                if (cnt_q != CNT_FULL) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (pop) begin
                ptr_d = ptr_dec;
                cnt_d = cnt_q - CW'(1);
            end else if (sel == SEL_RET) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entry contents need no reset: an empty count makes them unreachable.
    always_ff @(posedge clk) begin
        if (!stall && push) begin
            ras_mem[ptr_q] <= seq_addr;
        end
    end

    assign ras_empty = empty;
    assign ras_err   = err_q;
`else
    logic unused_call;

    assign unused_call = call;
    assign ret_hit     = 1'b0;
    assign ret_addr    = seq_addr;
    assign ras_empty   = 1'b1;
    assign ras_err     = 1'b0;
`endif

    always_comb begin
        pc_next = seq_addr;
        case (sel)
            SEL_SEQ: pc_next = seq_addr;
            SEL_BR:  pc_next = pc_q + offset;
            SEL_JMP: pc_next = target;
            SEL_RET: pc_next = ret_hit ? ret_addr : seq_addr;
            default: pc_next = seq_addr;
        endcase
    end

    assign pc_d = stall ? pc_q : pc_next;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer, expectations follow PC_SEQ_RAS_EN
module tb_pc_sequencer;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk;
    logic        clr_n;
    logic        stall;
    logic [1:0]  sel;
    logic [31:0] offset;
    logic [31:0] target;
    logic        call;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        ras_empty;
    logic        ras_err;

    pc_sequencer #(
        .W(32), .STEP(1), .RESET_ADDR(32'h0), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .clr_n(clr_n), .stall(stall), .sel(sel),
        .offset(offset), .target(target), .call(call),
        .pc(pc), .pc_next(pc_next), .ras_empty(ras_empty), .ras_err(ras_err)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        empty;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at a negedge; drives one cycle, checks pc_next, queues the post-edge state.
    task automatic step(input string name, input logic [1:0] s, input logic [31:0] off,
                        input logic [31:0] tgt, input logic c, input logic st,
                        input logic [31:0] nx, input logic [31:0] exp_pc,
                        input logic e_empty, input logic e_err);
        exp_t e;
        sel = s; offset = off; target = tgt; call = c; stall = st;
        #1;
        check({name, "/pc_next"}, pc_next, nx);
        e.name = name; e.pc = exp_pc; e.empty = e_empty; e.err = e_err;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "/pc"}, pc, e.pc);
                check({e.name, "/ras_empty"}, 32'(ras_empty), 32'(e.empty));
                check({e.name, "/ras_err"}, 32'(ras_err), 32'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clr_n = 1'b0; stall = 1'b0; sel = 2'b00; offset = '0; target = '0; call = 1'b0;
        #12;
        check("reset/pc", pc, 32'h0);
        check("reset/ras_empty", 32'(ras_empty), 32'h1);
        check("reset/ras_err", 32'(ras_err), 32'h0);
        @(negedge clk);
        clr_n = 1'b1;

        step("seq0",   2'b00, 0, 0, 0, 0, 32'h1, 32'h1, 1, 0);
        step("seq1",   2'b00, 0, 0, 0, 0, 32'h2, 32'h2, 1, 0);
        step("seq2",   2'b00, 0, 0, 0, 0, 32'h3, 32'h3, 1, 0);
        step("stall0", 2'b00, 0, 0, 0, 1, 32'h4, 32'h3, 1, 0);
        step("stall1", 2'b10, 0, 32'h999, 1, 1, 32'h999, 32'h3, 1, 0);
        step("seq3",   2'b00, 0, 0, 0, 0, 32'h4, 32'h4, 1, 0);

        step("jmp_0a",   2'b10, 0, 32'h0A, 0, 0, 32'h0A, 32'h0A, 1, 0);
        step("br_back",  2'b01, 32'hFFFFFFFC, 0, 0, 0, 32'h06, 32'h06, 1, 0);
        step("br_fwd",   2'b01, 32'h10, 0, 0, 0, 32'h16, 32'h16, 1, 0);
        step("jmp_top",  2'b10, 0, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        step("seq_wrap", 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
        step("br_wrap",  2'b01, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
        step("jmp_20",   2'b10, 0, 32'h20, 0, 0, 32'h20, 32'h20, 1, 0);

        step("call_100", 2'b10, 0, 32'h100, 1, 0, 32'h100, 32'h100, !RAS, 0);
        step("seq_101",  2'b00, 0, 0, 0, 0, 32'h101, 32'h101, !RAS, 0);
        step("ret_21",   2'b11, 0, 0, 0, 0, RAS ? 32'h21 : 32'h102, RAS ? 32'h21 : 32'h102, 1, 0);
        step("br_call",  2'b01, 0, 0, 1, 0, RAS ? 32'h21 : 32'h102, RAS ? 32'h21 : 32'h102, 1, 0);

        step("jmp_10", 2'b10, 0, 32'h10, 0, 0, 32'h10, 32'h10, 1, 0);
        for (int i = 1; i <= 5; i++)
            step($sformatf("call%0d", i), 2'b10, 0, 32'(i * 16 + 16), 1, 0,
                 32'(i * 16 + 16), 32'(i * 16 + 16), !RAS, 0);
        for (int i = 0; i < 4; i++)
            step($sformatf("ret%0d", i), 2'b11, 0, 0, 0, 0,
                 RAS ? 32'(16 * (5 - i) + 1) : 32'(32'h61 + i),
                 RAS ? 32'(16 * (5 - i) + 1) : 32'(32'h61 + i),
                 RAS ? (i == 3) : 1'b1, 0);
        step("ret_empty", 2'b11, 0, 0, 0, 0, RAS ? 32'h22 : 32'h65, RAS ? 32'h22 : 32'h65, 1, RAS);
        step("err_hold",  2'b00, 0, 0, 0, 0, RAS ? 32'h23 : 32'h66, RAS ? 32'h23 : 32'h66, 1, RAS);

        step("call_52", 2'b10, 0, 32'h52, 1, 0, 32'h52, 32'h52, !RAS, RAS);
        step("call_54", 2'b10, 0, 32'h54, 1, 0, 32'h54, 32'h54, !RAS, RAS);
        step("seq_55",  2'b00, 0, 0, 0, 0, 32'h55, 32'h55, !RAS, RAS);

        stall = 1'b1; sel = 2'b11; call = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        check("async/pc", pc, 32'h0);
        check("async/ras_empty", 32'(ras_empty), 32'h1);
        check("async/ras_err", 32'(ras_err), 32'h0);
        check("async/pc_next", pc_next, 32'h1);
        @(negedge clk);
        clr_n = 1'b1;
        step("rst_stall", 2'b00, 0, 0, 0, 1, 32'h1, 32'h0, 1, 0);
        step("rst_first", 2'b00, 0, 0, 0, 0, 32'h1, 32'h1, 1, 0);

        step("jmp_7",   2'b10, 0, 32'h7, 0, 0, 32'h7, 32'h7, 1, 0);
        step("ret_7",   2'b11, 0, 0, 0, 0, 32'h8, 32'h8, 1, RAS);
        step("call_40", 2'b10, 0, 32'h40, 1, 0, 32'h40, 32'h40, !RAS, RAS);

        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
